alu_cmd_ctrl: RTL and testbench
===============================

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  DATA_W  8  operand width
  DEBOUNCE_CYCLES  500000  stable-level cycles to accept a button change (10 ms at 50 MHz)
  TIMEOUT_CYCLES  1024  max cycles to wait for alu_done
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  system clock, CLOCK_50 domain
  rst  in  1  reset, asynchronous, active-high
  key_start_n  in  1  raw start push-button, active-low, asynchronous
  sw  in  2*DATA_W+2  raw switches: [DATA_W-1:0]=a, [2*DATA_W-1:DATA_W]=b, top 2 bits=opcode
  alu_done  in  1  completion flag from the ALU
  start  out  1  single-cycle command strobe to the ALU
  a  out  DATA_W  latched operand a
  b  out  DATA_W  latched operand b
  opcode  out  2  latched opcode
  busy  out  1  command in flight
  timeout  out  1  sticky: last command got no alu_done
  cmd_count  out  8  completed-command counter

Function
REQ-003 key_start_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-004 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-005 A press event SHALL be one cycle, generated on a debounced 1->0 transition; holding the button SHALL produce no further events.
REQ-006 FSM states SHALL be IDLE, ISSUE, WAIT; busy SHALL be 1 in ISSUE and WAIT.
REQ-007 IDLE: on a press event, latch sw into a, b, opcode, clear timeout, go to ISSUE.
REQ-008 ISSUE: start=1 for exactly one cycle; go to WAIT and clear the timeout counter.
REQ-009 WAIT: alu_done SHALL be recognised only on a rising edge (alu_done=1 with the registered prior value 0).
REQ-010 WAIT, done recognised: cmd_count increments by 1, wrapping 255->0, and the FSM returns to IDLE.
REQ-011 WAIT, no done after TIMEOUT_CYCLES cycles: set timeout=1, leave cmd_count unchanged, return to IDLE.
REQ-012 A done edge and timeout expiry in the same cycle SHALL be treated as done.
REQ-013 Press events in ISSUE or WAIT SHALL be discarded, not queued.
REQ-014 a, b, opcode SHALL hold their latched values between commands; sw changes while busy SHALL have no effect.
REQ-015 Latency: press event in cycle N -> start=1 in cycle N+1; the sw value latched is the one sampled in cycle N.

Reset
REQ-016 While rst=1, SHALL set: state=IDLE; start, busy, timeout=0; a, b, opcode, cmd_count=0; synchronizer flops and debounced level=1 (released); all counters 0.
REQ-017 rst asserted mid-command SHALL abort immediately with no start pulse; after rst release, no press event without a new qualified press.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-018 Clean press: sw a=0x12 b=0x34 opcode=2, key held low for 10 cycles -> exactly one start pulse; a=0x12, b=0x34, opcode=2; alu_done rise 3 cycles later -> cmd_count=1, busy=0.
REQ-019 Bounce: key toggles every 2 cycles for 20 cycles, then released -> no start pulse, cmd_count unchanged.
REQ-020 Busy lockout: second qualified press and sw change during WAIT -> no second start; a, b, opcode keep their first values.
REQ-021 Timeout: press, alu_done held 0 -> busy falls 16 cycles after WAIT entry, timeout=1, cmd_count unchanged; next press -> timeout=0.
REQ-022 Wrap: 256 completed commands -> cmd_count returns to 0x00.
REQ-023 Reset mid-WAIT: rst pulse during WAIT -> all outputs at reset values, key held low through release -> no start until key is released and pressed again.

Source files
------------

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: debounced push-button front end issuing single ALU commands with done/timeout tracking
module alu_cmd_ctrl #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_start_n,
  input  logic [2*DATA_W+1:0]   sw,
  input  logic                  alu_done,
  output logic                  start,
  output logic [DATA_W-1:0]     a,
  output logic [DATA_W-1:0]     b,
  output logic [1:0]            opcode,
  output logic                  busy,
  output logic                  timeout,
  output logic [7:0]            cmd_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic [1:0] sync;
  logic key_s, deb, deb_q, armed, press, done_q, done_rise, tmo_hit, in_wait;
  logic [DW-1:0] deb_cnt, rel_cnt;
  logic [TW-1:0] tcnt;
  assign key_s     = sync[1];
  // armed blocks a press until the key has been seen released long enough after reset
  assign press     = armed && deb_q && !deb;
  assign done_rise = alu_done && !done_q;
  assign tmo_hit   = tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign in_wait   = state != IDLE && state != ISSUE;
  assign start     = state == ISSUE;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync    <= 2'b11;
      deb     <= 1'b1;
      deb_q   <= 1'b1;
      deb_cnt <= '0;
      rel_cnt <= '0;
      armed   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync   <= {sync[0], key_start_n};
      deb_q  <= deb;
      done_q <= alu_done;
      if (key_s == deb) deb_cnt <= '0;
      else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb     <= key_s;
        deb_cnt <= '0;
      end else deb_cnt <= deb_cnt + 1'b1;
      if (!key_s) rel_cnt <= '0;
      else if (rel_cnt == DW'(DEBOUNCE_CYCLES - 1)) armed <= 1'b1;
      else rel_cnt <= rel_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (press ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               (done_rise || tmo_hit) ? IDLE : WAIT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      b         <= '0;
      opcode    <= '0;
      timeout   <= 1'b0;
      cmd_count <= '0;
      tcnt      <= '0;
    end else begin
      if (state == IDLE && press) begin
        a       <= sw[DATA_W-1:0];
        b       <= sw[2*DATA_W-1:DATA_W];
        opcode  <= sw[2*DATA_W+1:2*DATA_W];
        timeout <= 1'b0;
      end
      if (state == ISSUE) tcnt <= '0;
      else if (in_wait) tcnt <= tcnt + 1'b1;
      // a done edge wins over a simultaneous expiry
      if (in_wait && done_rise) cmd_count <= cmd_count + 8'd1;
      else if (in_wait && tmo_hit) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: randomized scoreboard bench for alu_cmd_ctrl
module tb_alu_cmd_ctrl;
  logic clk = 1'b0;
  logic rst, key, alu_done;
  logic [17:0] sw;
  logic start, busy, timeout;
  logic [7:0] a, b, cmd_count;
  logic [1:0] opcode;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       to;
    logic [7:0] cnt;
    int         len;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int vecs = 0, errs = 0;
  int resp_k = -1, rk, mlen, mextra;
  bit mabort;
  logic [7:0] cnt_m = 8'd0;

  alu_cmd_ctrl #(.DATA_W(8), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .key_start_n(key), .sw(sw), .alu_done(alu_done),
    .start(start), .a(a), .b(b), .opcode(opcode), .busy(busy),
    .timeout(timeout), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      step();
      n++;
    end
    if (busy) chk("idle_bound", 32'(busy), 32'd0);
  endtask

  // k = cycles after the start cycle at which alu_done rises; -1 = never
  task automatic cmd(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop, input int k);
    exp_t e;
    resp_k = k;
    sw = {iop, ib, ia};
    e.a = ia; e.b = ib; e.op = iop;
    e.to = !(k >= 1 && k <= 16);
    if (!e.to) cnt_m = cnt_m + 8'd1;
    e.cnt = cnt_m;
    e.len = e.to ? 17 : k + 1;
    q.push_back(e);
    key = 1'b0;
    repeat (10) step();
    sw = 18'($urandom);
    key = 1'b1;
    wait_idle();
    repeat (8) step();
  endtask

  // responder: drives one alu_done pulse per start after resp_k cycles
  initial begin
    alu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (start && !rst && resp_k >= 0) begin
        rk = resp_k;
        repeat (rk) @(negedge clk);
        alu_done = 1'b1;
        repeat (2) @(negedge clk);
        alu_done = 1'b0;
      end
    end
  end

  // monitor: every start pops one expected command and follows it to completion
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && start) begin
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_start: got start=1 expected no command");
        end else begin
          me = q.pop_front();
          chk("a_latch", 32'(a), 32'(me.a));
          chk("b_latch", 32'(b), 32'(me.b));
          chk("op_latch", 32'(opcode), 32'(me.op));
          chk("timeout_clear", 32'(timeout), 32'd0);
          mlen = 1; mextra = 0; mabort = 1'b0;
          while (mlen < 100) begin
            @(negedge clk);
            if (rst) begin
              mabort = 1'b1;
              break;
            end
            if (!busy) break;
            if (start) mextra++;
            mlen++;
          end
          if (!mabort) begin
            chk("busy_len", 32'(mlen), 32'(me.len));
            chk("cmd_count", 32'(cmd_count), 32'(me.cnt));
            chk("timeout", 32'(timeout), 32'(me.to));
            chk("a_hold", 32'(a), 32'(me.a));
            chk("b_hold", 32'(b), 32'(me.b));
            chk("op_hold", 32'(opcode), 32'(me.op));
            chk("extra_start", 32'(mextra), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; key = 1'b1; sw = '0;
    repeat (3) step();
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_b", 32'(b), 32'd0);
    chk("rst_op", 32'(opcode), 32'd0);
    chk("rst_count", 32'(cmd_count), 32'd0);
    rst = 1'b0;
    repeat (10) step();
    cmd(8'h12, 8'h34, 2'd2, 3);
    for (int i = 0; i < 20; i++) begin
      key = ((i / 2) % 2) != 0;
      step();
    end
    key = 1'b1;
    repeat (12) step();
    chk("bounce_count", 32'(cmd_count), 32'(cnt_m));
    chk("bounce_busy", 32'(busy), 32'd0);
    cmd(8'($urandom), 8'($urandom), 2'($urandom), -1);
    cmd(8'($urandom), 8'($urandom), 2'($urandom), 16);
    cmd(8'($urandom), 8'($urandom), 2'($urandom), 17);
    cmd(8'($urandom), 8'($urandom), 2'($urandom), 0);
    cmd(8'($urandom), 8'($urandom), 2'($urandom), 1);
    begin : lockout
      exp_t e;
      resp_k = -1;
      sw = {2'd1, 8'hAB, 8'hCD};
      e.a = 8'hCD; e.b = 8'hAB; e.op = 2'd1; e.to = 1'b1; e.cnt = cnt_m; e.len = 17;
      q.push_back(e);
      key = 1'b0;
      repeat (8) step();
      key = 1'b1;
      repeat (6) step();
      sw = 18'($urandom);
      key = 1'b0;
      repeat (10) step();
      key = 1'b1;
      wait_idle();
      repeat (8) step();
    end
    repeat (40) cmd(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 20)));
    begin : mid_reset
      exp_t e;
      resp_k = -1;
      sw = {2'd3, 8'h55, 8'hAA};
      e.a = 8'hAA; e.b = 8'h55; e.op = 2'd3; e.to = 1'b1; e.cnt = cnt_m; e.len = 17;
      q.push_back(e);
      key = 1'b0;
      repeat (10) step();
      rst = 1'b1;
      #1;
      chk("mrst_start", 32'(start), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_timeout", 32'(timeout), 32'd0);
      chk("mrst_a", 32'(a), 32'd0);
      chk("mrst_b", 32'(b), 32'd0);
      chk("mrst_op", 32'(opcode), 32'd0);
      chk("mrst_count", 32'(cmd_count), 32'd0);
      repeat (3) step();
      cnt_m = 8'd0;
      rst = 1'b0;
      repeat (20) step();
      chk("held_no_cmd", 32'(busy), 32'd0);
      key = 1'b1;
      repeat (10) step();
      cmd(8'($urandom), 8'($urandom), 2'($urandom), 5);
    end
    repeat (256 - int'(cnt_m)) cmd(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(1, 16)));
    chk("wrap_count", 32'(cmd_count), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
